// File: rtl/waddr_if.sv
// AXI write-address and write-response signals shared by the waddr_channel
// master port and whatever sits on the slave side.
//   awaddr  [63:0] burst address         awlen [7:0] burst length
//   awvalid / awready                    AW handshake
//   bvalid / bready                      B handshake
//   bresp   [1:0]  write response code
interface waddr_if;
  logic [63:0] awaddr;
  logic [7:0]  awlen;
  logic        awvalid;
  logic        awready;
  logic        bvalid;
  logic [1:0]  bresp;
  logic        bready;

  modport master (
    output awaddr, awlen, awvalid, bready,
    input  awready, bvalid, bresp
  );

  modport slave (
    input  awaddr, awlen, awvalid, bready,
    output awready, bvalid, bresp
  );
endinterface

// File: rtl/waddr_channel.sv
// Write-address issuer. Walks a (w1+1)x(h1+1) block grid and issues one AW
// burst per block at BLK_BYTES-spaced addresses starting at dest_address.
// Each burst needs one credit (blk_pulse from the output block buffer) and a
// free outstanding slot; B responses retire outstanding bursts. done_pulse
// fires once every burst of the frame has been acknowledged.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   m_axi             AW/B channel (waddr_if.master)
//   start_pulse       one-cycle frame start (accepted only when idle)
//   dest_address      frame base address, sampled on accepted start
//   w1, h1            last x / y block index (inclusive), sampled on start
//   blk_pulse         one-cycle credit: one block buffered
//   busy              high whenever not idle
//   done_pulse        one-cycle frame completion
//   err               sticky bad-response flag
//
// Optional feature: define WADDR_BRESP_CHECK_EN to flag non-OKAY B responses
// on err. Without it err is tied low and bresp is ignored.
module waddr_channel #(
  parameter int unsigned BLK_BYTES       = 384,
  parameter int unsigned BURST_LEN       = 2,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  waddr_if.master      m_axi,
  input  logic         start_pulse,
  input  logic [63:0]  dest_address,
  input  logic [9:0]   w1,
  input  logic [9:0]   h1,
  input  logic         blk_pulse,
  output logic         busy,
  output logic         done_pulse,
  output logic         err
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_ADDR  = 4'b0010,
    S_SEND  = 4'b0100,
    S_DRAIN = 4'b1000
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [63:0] r_dest;
  logic [9:0]  r_w1;
  logic [9:0]  r_h1;
  logic [63:0] r_awaddr;
  logic [9:0]  r_x;
  logic [10:0] r_y;      // one extra bit so y = h1+1 is representable at h1 = 1023
  logic        r_first;
  logic [7:0]  r_credit;
  logic [OW-1:0] r_out;

  logic w_start_acc;
  logic w_frame_end;
  logic w_can_issue;
  logic w_issue;
  logic w_aw_hs;
  logic w_b_hs;
  logic w_cr_inc;
  logic w_out_dec;

  assign w_start_acc = (r_state == S_IDLE) && start_pulse;
  assign w_frame_end = (r_y > {1'b0, r_h1});
  assign w_can_issue = (r_credit != 8'd0) && (r_out < OW'(MAX_OUTSTANDING));
  assign w_issue     = (r_state == S_ADDR) && !w_frame_end && w_can_issue;
  assign w_aw_hs     = (r_state == S_SEND) && m_axi.awready;
  assign w_b_hs      = m_axi.bready && m_axi.bvalid;
  // Credits arriving while idle belong to no frame; saturate at 255.
  assign w_cr_inc    = blk_pulse && (r_state != S_IDLE) && (r_credit != 8'hFF);
  // A response with nothing outstanding cannot belong to us.
  assign w_out_dec   = w_b_hs && (r_out != '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start_pulse) w_next = S_ADDR;
      S_ADDR: begin
        if (w_frame_end)      w_next = S_DRAIN;
        else if (w_can_issue) w_next = S_SEND;
      end
      S_SEND:  if (m_axi.awready) w_next = S_ADDR;
      S_DRAIN: if (r_out == '0)   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode; awvalid is the SEND state flop, so it is registered.
  assign m_axi.awaddr  = r_awaddr;
  assign m_axi.awlen   = 8'(BURST_LEN);
  assign m_axi.awvalid = (r_state == S_SEND);
  assign m_axi.bready  = (r_state != S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign done_pulse    = (r_state == S_DRAIN) && (r_out == '0);

  // Frame configuration, captured on an accepted start
  always_ff @(posedge clk) begin
    if (w_start_acc) begin
      r_dest <= dest_address;
      r_w1   <= w1;
      r_h1   <= h1;
    end
  end

  // Address generation, grid walk and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_awaddr <= 64'd0;
      r_x      <= 10'd0;
      r_y      <= 11'd0;
      r_first  <= 1'b0;
      r_credit <= 8'd0;
      r_out    <= '0;
    end else begin
      if (w_start_acc) begin
        r_x     <= 10'd0;
        r_y     <= 11'd0;
        r_first <= 1'b1;
      end else if (w_issue) begin
        r_awaddr <= r_first ? r_dest : (r_awaddr + 64'(BLK_BYTES));
        r_first  <= 1'b0;
        if (r_x >= r_w1) begin
          r_x <= 10'd0;
          r_y <= r_y + 11'd1;
        end else begin
          r_x <= r_x + 10'd1;
        end
      end

      if (w_start_acc)               r_credit <= 8'd0;
      else if (w_cr_inc && !w_aw_hs) r_credit <= r_credit + 8'd1;
      else if (!w_cr_inc && w_aw_hs) r_credit <= r_credit - 8'd1;

      if (w_start_acc)                r_out <= '0;
      else if (w_aw_hs && !w_out_dec) r_out <= r_out + OW'(1);
      else if (!w_aw_hs && w_out_dec) r_out <= r_out - OW'(1);
    end
  end

`ifdef WADDR_BRESP_CHECK_EN
  logic r_err;

  // Sticky until the next accepted start; the frame itself still completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              r_err <= 1'b0;
    else if (w_start_acc)                    r_err <= 1'b0;
    else if (w_b_hs && m_axi.bresp != 2'b00) r_err <= 1'b1;
  end

  assign err = r_err;
`else
  logic w_unused_bresp;

  assign w_unused_bresp = ^m_axi.bresp;
  assign err            = 1'b0;
`endif

endmodule
